// File: rtl/accel_mmap_regs_if.sv
// Host request/response bus for accel_mmap_regs.
//   master : host side, drives requests and accepts responses
//   slave  : register block side, accepts requests and returns responses
// One request is outstanding at a time. A request transfers on
// req_valid && req_ready, and a response transfers on rsp_valid && rsp_ready.
interface accel_mmap_regs_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/accel_mmap_regs.sv
// Control/status register file that sits between the host bus and the
// accelerator core.
//   clk, rst_n             : clock and asynchronous active-low reset
//   bus (slave)            : host request/response channel. A request is
//                            decoded in the cycle it is accepted, and the
//                            response follows one cycle later.
//   accel_start            : one-cycle start pulse to the core
//   accel_busy             : set when a start is issued, cleared by core_done
//   core_done              : one-cycle completion pulse from the core
//   *_addr                 : preproc/postproc address window registers
//   *_buff_full/empty      : core buffer status, readable at indices 6..9
module accel_mmap_regs #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    accel_mmap_regs_if.slave  bus,
    output logic              accel_start,
    output logic              accel_busy,
    input  logic              core_done,
    output logic [DATA_W-1:0] preproc_start_addr,
    output logic [DATA_W-1:0] preproc_end_addr,
    output logic [DATA_W-1:0] postproc_start_addr,
    output logic [DATA_W-1:0] postproc_end_addr,
    input  logic              input_buff_full,
    input  logic              input_buff_empty,
    input  logic              output_buff_full,
    input  logic              output_buff_empty
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam logic [ADDR_W-1:0] IDX_START     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] IDX_PRE_START = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_PRE_END   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] IDX_PST_START = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] IDX_PST_END   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] IDX_IN_FULL   = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] IDX_IN_EMPTY  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] IDX_OUT_FULL  = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] IDX_OUT_EMPTY = ADDR_W'(9);

    logic [0:0]        state;
    logic              accept;
    logic              win_ok;
    logic              start_ok;
    logic              err_d;
    logic [DATA_W-1:0] rdata_d;
    logic              we_pre_start, we_pre_end, we_pst_start, we_pst_end;

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid && (state == ST_IDLE);

    // A start is legal only when both windows are non-inverted (unsigned).
    assign win_ok = (preproc_end_addr >= preproc_start_addr) &&
                    (postproc_end_addr >= postproc_start_addr);

    // Decode the request against the pre-edge state. If core_done lands in
    // the accept cycle, the busy check still uses the old value of 1.
    always_comb begin
        rdata_d      = '0;
        err_d        = 1'b0;
        start_ok     = 1'b0;
        we_pre_start = 1'b0;
        we_pre_end   = 1'b0;
        we_pst_start = 1'b0;
        we_pst_end   = 1'b0;
        if (bus.req_wr) begin
            case (bus.req_addr)
                IDX_START: begin
                    if (bus.req_wdata[0]) begin
                        if (!accel_busy && win_ok) start_ok = 1'b1;
                        else                       err_d    = 1'b1;
                    end
                end
                IDX_PRE_START: if (accel_busy) err_d = 1'b1; else we_pre_start = 1'b1;
                IDX_PRE_END:   if (accel_busy) err_d = 1'b1; else we_pre_end   = 1'b1;
                IDX_PST_START: if (accel_busy) err_d = 1'b1; else we_pst_start = 1'b1;
                IDX_PST_END:   if (accel_busy) err_d = 1'b1; else we_pst_end   = 1'b1;
                default:       err_d = 1'b1;
            endcase
        end else begin
            case (bus.req_addr)
                IDX_START:     rdata_d = {{(DATA_W-1){1'b0}}, accel_busy};
                IDX_PRE_START: rdata_d = preproc_start_addr;
                IDX_PRE_END:   rdata_d = preproc_end_addr;
                IDX_PST_START: rdata_d = postproc_start_addr;
                IDX_PST_END:   rdata_d = postproc_end_addr;
                IDX_IN_FULL:   rdata_d = {{(DATA_W-1){1'b0}}, input_buff_full};
                IDX_IN_EMPTY:  rdata_d = {{(DATA_W-1){1'b0}}, input_buff_empty};
                IDX_OUT_FULL:  rdata_d = {{(DATA_W-1){1'b0}}, output_buff_full};
                IDX_OUT_EMPTY: rdata_d = {{(DATA_W-1){1'b0}}, output_buff_empty};
                default:       err_d   = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_rdata       <= '0;
            bus.rsp_err         <= 1'b0;
            accel_start         <= 1'b0;
            accel_busy          <= 1'b0;
            preproc_start_addr  <= '0;
            preproc_end_addr    <= '0;
            postproc_start_addr <= '0;
            postproc_end_addr   <= '0;
        end else begin
            accel_start <= accept && start_ok;

            // A start is only granted while not busy, so it never competes
            // with core_done for the same edge.
            if (accept && start_ok) accel_busy <= 1'b1;
            else if (core_done)     accel_busy <= 1'b0;

            if (accept && we_pre_start) preproc_start_addr  <= bus.req_wdata;
            if (accept && we_pre_end)   preproc_end_addr    <= bus.req_wdata;
            if (accept && we_pst_start) postproc_start_addr <= bus.req_wdata;
            if (accept && we_pst_end)   postproc_end_addr   <= bus.req_wdata;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= rdata_d;
                        bus.rsp_err   <= err_d;
                        state         <= ST_RESP;
                    end
                end
                default: begin
                    // rdata/err are held until the host takes the response
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_mmap_regs.sv
module tb_accel_mmap_regs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic accel_start, accel_busy, core_done;
    logic [31:0] preproc_start_addr, preproc_end_addr, postproc_start_addr, postproc_end_addr;
    logic input_buff_full, input_buff_empty, output_buff_full, output_buff_empty;

    accel_mmap_regs_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    accel_mmap_regs #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .accel_start(accel_start), .accel_busy(accel_busy), .core_done(core_done),
        .preproc_start_addr(preproc_start_addr), .preproc_end_addr(preproc_end_addr),
        .postproc_start_addr(postproc_start_addr), .postproc_end_addr(postproc_end_addr),
        .input_buff_full(input_buff_full), .input_buff_empty(input_buff_empty),
        .output_buff_full(output_buff_full), .output_buff_empty(output_buff_empty)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_reg [1:4];
    bit          m_busy, m_start, m_pend, m_err;
    logic [31:0] m_rdata;

    function automatic void model_reset();
        for (int i = 1; i <= 4; i++) m_reg[i] = '0;
        m_busy = 0; m_start = 0; m_pend = 0; m_err = 0; m_rdata = '0;
    endfunction

    // Advance the model by one clock edge using the inputs presented before it.
    function automatic void model_step();
        bit acc, nb, ns, e;
        logic [31:0] r;
        int a;
        if (!rst_n) return;
        acc = bus.req_valid && !m_pend;
        a   = int'(bus.req_addr);
        nb  = m_busy && !core_done;
        ns  = 0;
        if (m_pend && bus.rsp_ready) m_pend = 0;
        if (acc) begin
            r = '0; e = 0;
            if (bus.req_wr) begin
                if (a == 0) begin
                    if (bus.req_wdata[0]) begin
                        if (!m_busy && m_reg[2] >= m_reg[1] && m_reg[4] >= m_reg[3]) begin
                            ns = 1; nb = 1;
                        end else e = 1;
                    end
                end else if (a >= 1 && a <= 4) begin
                    if (m_busy) e = 1; else m_reg[a] = bus.req_wdata;
                end else e = 1;
            end else begin
                if (a == 0)                r = {31'b0, m_busy};
                else if (a >= 1 && a <= 4) r = m_reg[a];
                else if (a == 6)           r = {31'b0, input_buff_full};
                else if (a == 7)           r = {31'b0, input_buff_empty};
                else if (a == 8)           r = {31'b0, output_buff_full};
                else if (a == 9)           r = {31'b0, output_buff_empty};
                else                       e = 1;
            end
            m_pend = 1; m_rdata = r; m_err = e;
        end
        m_busy  = nb;
        m_start = ns;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(!m_pend));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_pend));
            if (m_pend) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
            end
            chk("accel_start", 32'(accel_start), 32'(m_start));
            chk("accel_busy", 32'(accel_busy), 32'(m_busy));
            chk("preproc_start_addr", preproc_start_addr, m_reg[1]);
            chk("preproc_end_addr", preproc_end_addr, m_reg[2]);
            chk("postproc_start_addr", postproc_start_addr, m_reg[3]);
            chk("postproc_end_addr", postproc_end_addr, m_reg[4]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    logic [31:0] r_data;
    logic        r_err, st_acc, st_after;

    // Single request with rsp_ready held high. Response is expected one
    // cycle after accept and is consumed on the following edge.
    task automatic do_req(input bit wr, input int addr, input logic [31:0] wd);
        bus.req_valid = 1; bus.req_wr = wr; bus.req_addr = 8'(addr);
        bus.req_wdata = wd; bus.rsp_ready = 1;
        cycle();
        bus.req_valid = 0;
        chk("rsp_latency", 32'(bus.rsp_valid), 32'd1);
        r_data = bus.rsp_rdata; r_err = bus.rsp_err; st_acc = accel_start;
        cycle();
        st_after = accel_start;
    endtask

    initial begin
        bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 0; core_done = 0;
        input_buff_full = 0; input_buff_empty = 0; output_buff_full = 0; output_buff_empty = 0;
        model_reset();
        chk_en = 1;
        cycle(); cycle();
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_busy", 32'(accel_busy), 32'd0);
        chk("reset_preproc_start", preproc_start_addr, 32'd0);
        chk("reset_postproc_end", postproc_end_addr, 32'd0);
        rst_n = 1;
        cycle();

        do_req(0, 1, 0);
        chk("rd1_data", r_data, 32'd0);
        chk("rd1_err", 32'(r_err), 32'd0);

        // valid windows, then start
        do_req(1, 1, 32'h100);
        do_req(1, 2, 32'h1FF);
        do_req(1, 3, 32'h200);
        do_req(1, 4, 32'h2FF);
        do_req(1, 0, 32'h1);
        chk("start_err", 32'(r_err), 32'd0);
        chk("start_pulse", 32'(st_acc), 32'd1);
        chk("start_pulse_end", 32'(st_after), 32'd0);
        chk("busy_set", 32'(accel_busy), 32'd1);
        do_req(0, 0, 0);
        chk("rd0_busy", r_data, 32'h1);

        // writes while busy
        do_req(1, 1, 32'h300);
        chk("busy_wr_err", 32'(r_err), 32'd1);
        chk("busy_wr_hold", preproc_start_addr, 32'h100);
        do_req(1, 0, 32'h1);
        chk("busy_start_err", 32'(r_err), 32'd1);
        chk("busy_start_nopulse", 32'(st_acc), 32'd0);
        core_done = 1;
        cycle();
        core_done = 0;
        chk("done_clears_busy", 32'(accel_busy), 32'd0);

        // inverted preproc window
        do_req(1, 1, 32'h500);
        do_req(1, 2, 32'h4FF);
        do_req(1, 0, 32'h1);
        chk("badwin_err", 32'(r_err), 32'd1);
        chk("badwin_nopulse", 32'(st_acc), 32'd0);
        chk("badwin_busy", 32'(accel_busy), 32'd0);

        // status flags and bad indices
        input_buff_full = 1; output_buff_empty = 1;
        do_req(0, 6, 0); chk("rd6", r_data, 32'd1);
        do_req(0, 7, 0); chk("rd7", r_data, 32'd0);
        do_req(0, 8, 0); chk("rd8", r_data, 32'd0);
        do_req(0, 9, 0); chk("rd9", r_data, 32'd1);
        do_req(0, 5, 0); chk("rd5_data", r_data, 32'd0); chk("rd5_err", 32'(r_err), 32'd1);
        do_req(1, 8, 32'h1); chk("wr8_err", 32'(r_err), 32'd1);

        // response held under backpressure, then reset mid-hold
        bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = 8'd1; bus.rsp_ready = 0;
        cycle();
        bus.req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rdata", bus.rsp_rdata, 32'h500);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
            cycle();
        end
        #2;
        rst_n = 0;
        model_reset();
        cycle();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1;
        cycle();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid2", 32'(bus.rsp_valid), 32'd0);
        chk("rst_regs", preproc_start_addr, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.req_valid = ($urandom_range(0, 99) < 50);
            bus.req_wr    = $urandom_range(0, 1) == 1;
            bus.req_addr  = ($urandom_range(0, 99) < 85) ? 8'($urandom_range(0, 11))
                                                         : 8'($urandom_range(12, 255));
            bus.req_wdata = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
            bus.rsp_ready = ($urandom_range(0, 99) < 60);
            core_done     = ($urandom_range(0, 99) < 10);
            input_buff_full   = $urandom_range(0, 1) == 1;
            input_buff_empty  = $urandom_range(0, 1) == 1;
            output_buff_full  = $urandom_range(0, 1) == 1;
            output_buff_empty = $urandom_range(0, 1) == 1;
            cycle();
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/accel_mmap_regs.md
Name: accel_mmap_regs

Overview:
- Memory-mapped control/status register file between the host bus and the accelerator core.
- Holds the preproc/postproc address windows and issues the core start pulse.
- Tracks a busy flag until the core reports done.
- Exposes the core's four input/output buffer full/empty flags as read-only status registers.
- Word index map: 0 START_ACCEL, 1 PREPROC_START_ADDR, 2 PREPROC_END_ADDR, 3 POSTPROC_START_ADDR, 4 POSTPROC_END_ADDR, 5 RD_ONLY (reserved), 6 INPUT_BUFF_FULL, 7 INPUT_BUFF_EMPTY, 8 OUTPUT_BUFF_FULL, 9 OUTPUT_BUFF_EMPTY.

Parameters:
ADDR_W, 8, host word-index width; matches MMAP_WIDTH.
DATA_W, 32, host data and address-register width.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request valid
req_ready  output  1  block can accept a request
req_wr  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word index
req_wdata  input  DATA_W  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_err  output  1  access error
accel_start  output  1  one-cycle core start pulse
accel_busy  output  1  core running
core_done  input  1  one-cycle completion pulse from core
preproc_start_addr  output  DATA_W  register 1
preproc_end_addr  output  DATA_W  register 2
postproc_start_addr  output  DATA_W  register 3
postproc_end_addr  output  DATA_W  register 4
input_buff_full  input  1  core status
input_buff_empty  input  1  core status
output_buff_full  input  1  core status
output_buff_empty  input  1  core status

Behaviour:
- Reset values:
  - All outputs 0, except req_ready = 1.
  - FSM in IDLE.
  - Address registers 0.
- FSM IDLE:
  - req_ready = 1.
  - On req_valid, the request is captured and decoded that cycle; go to RESP.
  - rsp_valid = 1 on the next cycle (1-cycle latency).
- FSM RESP:
  - req_ready = 0; rsp_valid and rsp_rdata/rsp_err are held stable.
  - rsp_valid && rsp_ready → IDLE. The next request can be accepted in the cycle after that.
- Reads:
  - Index 0 returns {DATA_W-1 zeros, accel_busy}.
  - Indices 1–4 return the register.
  - Indices 6–9 return the corresponding flag zero-extended, sampled in the accept cycle.
  - Index 5 and indices ≥10 return 0 with rsp_err = 1.
- Writes to 1–4:
  - Update the register at the accept edge only when accel_busy = 0.
  - While busy: no update, rsp_err = 1.
- Writes to 0:
  - wdata[0] = 1 with accel_busy = 0 and both windows valid (end ≥ start, unsigned, for preproc and for postproc): accel_start = 1 for exactly the cycle after accept, and accel_busy is set on the same edge. rsp_err = 0.
  - wdata[0] = 1 while busy, or with an invalid window: no pulse, rsp_err = 1.
  - wdata[0] = 0: no-op, no error.
- Writes to 5–9 or ≥10: ignored, rsp_err = 1.
- Busy clear:
  - core_done clears accel_busy on the next edge.
  - core_done while accel_busy = 0 is ignored.
  - If core_done coincides with a start write being accepted, the busy check uses the pre-edge value. The write therefore errors, and busy ends the cycle cleared.
- Read of index 0 in the core_done cycle returns the pre-clear value 1.
- Reset mid-transaction: FSM returns to IDLE and any pending response is dropped; busy and registers are cleared.

Test Plan:
- Reset → req_ready = 1, rsp_valid = 0, accel_busy = 0, all address outputs 0; read index 1 → rdata 0, err 0.
- Write 1←0x100, 2←0x1FF, 3←0x200, 4←0x2FF, then write 0←1 → accel_start high exactly 1 cycle, accel_busy = 1; read index 0 → 0x1.
- While busy: write 1←0x300 → err = 1, preproc_start_addr stays 0x100; write 0←1 → err = 1, no pulse; pulse core_done → busy = 0 next cycle.
- Write 1←0x500, 2←0x4FF, then 0←1 → err = 1, no start, busy stays 0.
- Drive input_buff_full = 1, output_buff_empty = 1 → reads of 6 and 9 return 1, reads of 7 and 8 return 0; read 5 → rdata 0, err 1; write 8 → err 1.
- Hold rsp_ready = 0 for 5 cycles after a read → rsp_valid and rdata stable, req_ready = 0. Assert rst_n = 0 mid-hold → rsp_valid = 0 and req_ready = 1 after release.
